arm_mc_controller: RTL and testbench

Multicycle control unit for the ARM core. A main FSM sequences a shared datapath with one unified memory and one ALU, which is reused for PC+4, address generation and execution. The block decodes the held instruction register, drives every datapath select and write strobe, and owns the NZCV flags register and the conditional-execution check. It sits beside the multicycle datapath inside the core top, replacing the single-cycle controller.

---
 rtl/arm_mc_pkg.sv | 57 +++++
 rtl/arm_cond_unit.sv | 52 +++++
 rtl/arm_mc_controller.sv | 152 +++++++++++++++
 tb/tb_arm_mc_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// datapath select codes, condition codes and instruction field constants.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flags register with per-half write gating, and the condition check
// evaluated against the registered (pre-instruction) flags.
module arm_cond_unit
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    // NZ and CV halves load independently, only when the instruction executes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

    // Condition code evaluation; 1111 never executes
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main FSM, per-state datapath decode,
// ALU decoder, and strobe gating by the condition check.
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUControl,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic         RegWrite,
    output logic [3:0]   State
);

    state_t     state, state_next;
    logic [1:0] op;
    logic [3:0] cmd, cond;
    logic       funct_i, funct_s;
    logic       next_pc, branch, ir_write, mem_w, reg_w, alu_op;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       unused_instr_bits;

    assign cond    = Instr[31:28];
    assign op      = Instr[27:26];
    assign funct_i = Instr[25];
    assign cmd     = Instr[24:21];
    assign funct_s = Instr[20];
    // Rd/Rn fields belong to the datapath, not to control
    assign unused_instr_bits = ^Instr[19:12];

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign State  = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state logic; unused encodings fall back to FETCH
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:   state_next = funct_i ? S_EXECI : S_EXECR;
                    OP_MEM:  state_next = S_MEMADR;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = funct_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Per-state raw decode of selects and unconditioned strobes
    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR:  alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB:  reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; unrecognised commands add and never touch the flags
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: begin ALUControl = ALU_ADD; flag_w = {funct_s, funct_s}; end
                CMD_SUB: begin ALUControl = ALU_SUB; flag_w = {funct_s, funct_s}; end
                CMD_AND: begin ALUControl = ALU_AND; flag_w = {funct_s, 1'b0};    end
                CMD_ORR: begin ALUControl = ALU_ORR; flag_w = {funct_s, 1'b0};    end
                default: begin ALUControl = ALU_ADD; flag_w = 2'b00;              end
            endcase
        end
    end

    arm_cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .cond_ex   (cond_ex)
    );

    // Reset kills every strobe combinationally so an abort is immediate
    assign PCWrite  = reset && (next_pc || (branch && cond_ex));
    assign IRWrite  = reset && ir_write;
    assign RegWrite = reset && reg_w && cond_ex;
    assign MemWrite = reset && mem_w && cond_ex;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for the multicycle ARM controller: a step-indexed instruction model
// predicts every output each cycle, and directed sequences pin the model.
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = 20'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  State;

    int checks = 0;
    int failures = 0;
    int mstep = 0;
    logic [3:0] mflags = 4'h0;
    logic chk_en = 1'b0;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .State      (State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction classes expressed as the list of states they visit
    function automatic int path_len(input logic [19:0] ins);
        case (ins[15:14])
            2'b00:   return 4;
            2'b01:   return ins[8] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int path_state(input logic [19:0] ins, input int step);
        if (step == 0) return 0;
        if (step == 1) return 1;
        case (ins[15:14])
            2'b00:   return (step == 2) ? (ins[13] ? 7 : 6) : 8;
            2'b01:   return (step == 2) ? 2 : (step == 3) ? (ins[8] ? 3 : 5) : 4;
            2'b10:   return 9;
            default: return 0;
        endcase
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !cy || z;
            10: return n == v;
            11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // 0 ADD, 1 SUB, 2 AND, 3 ORR, -1 unrecognised
    function automatic int cmd_op(input logic [3:0] cmd);
        case (cmd)
            4'd4:  return 0;
            4'd2:  return 1;
            4'd0:  return 2;
            4'd12: return 3;
            default: return -1;
        endcase
    endfunction

    // Model: advance along the instruction's state list, latch flags after EXEC
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstep  <= 0;
            mflags <= 4'h0;
        end else begin
            int s, k;
            s = path_state(Instr, mstep);
            k = cmd_op(Instr[12:9]);
            mstep <= (mstep >= path_len(Instr) - 1) ? 0 : mstep + 1;
            if ((s == 6 || s == 7) && Instr[8] && k >= 0 && cond_ok(Instr[19:16], mflags)) begin
                mflags[3:2] <= ALUFlags[3:2];
                if (k <= 1) mflags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            int s, k, alu;
            bit ok, r;
            s  = path_state(Instr, mstep);
            ok = cond_ok(Instr[19:16], mflags);
            r  = reset;
            k  = cmd_op(Instr[12:9]);
            alu = ((s == 6 || s == 7) && k >= 0) ? k : 0;
            chk("State", State, s);
            chk("IRWrite", IRWrite, r && s == 0);
            chk("PCWrite", PCWrite, r && (s == 0 || (s == 9 && ok)));
            chk("MemWrite", MemWrite, r && s == 5 && ok);
            chk("RegWrite", RegWrite, r && (s == 4 || s == 8) && ok);
            chk("AdrSrc", AdrSrc, s == 3 || s == 5);
            chk("ResultSrc", ResultSrc, (s <= 1 || s == 9) ? 2 : (s == 4) ? 1 : 0);
            chk("ALUSrcA", ALUSrcA, s <= 1);
            chk("ALUSrcB", ALUSrcB, (s <= 1) ? 2 : (s == 2 || s == 7 || s == 9) ? 1 : 0);
            chk("ALUControl", ALUControl, alu);
            chk("ImmSrc", ImmSrc, Instr[15:14]);
            chk("RegSrc", RegSrc, {Instr[15:14] == 2'b01, Instr[15:14] == 2'b10});
        end
    end

    // Run one instruction from its FETCH; fl < 0 randomises ALUFlags each cycle
    task automatic do_instr(input logic [19:0] ins, input int fl,
                            output logic [31:0] seq, output int pcw_br,
                            output int mw, output int rw,
                            output int rd_adr, output int wb_res);
        int guard = 0;
        bit done = 0;
        seq = 0; pcw_br = -1; mw = 0; rw = 0; rd_adr = -1; wb_res = -1;
        while (mstep != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (mstep != 0) begin
            checks++; failures++;
            $display("FAIL fetch_wait timeout mstep=%0d", mstep);
        end
        Instr = ins;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (mstep == 0) begin
                    done = 1;
                    break;
                end
            end
            ALUFlags = (fl < 0) ? 4'($urandom) : 4'(fl);
            #2;
            seq = (seq << 4) | 32'(State);
            if (State == 4'd9) pcw_br = PCWrite;
            if (State == 4'd3) rd_adr = AdrSrc;
            if (State == 4'd4) wb_res = ResultSrc;
            mw += MemWrite;
            rw += RegWrite;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL instr_timeout instr=%h", ins);
        end
    endtask

    initial begin
        logic [31:0] seq;
        int pcw, mw, rw, ra, wr, guard;

        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_state", State, 0);
        chk("rst_strobes", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("first_irwrite", IRWrite, 1);
        chk("first_pcwrite", PCWrite, 1);
        #(-0);

        do_instr(20'hE0821, -1, seq, pcw, mw, rw, ra, wr);
        chk("add_path", seq, 32'h0168);
        chk("add_regwrites", rw, 1);
        chk("add_memwrites", mw, 0);

        do_instr(20'hE2500, 4, seq, pcw, mw, rw, ra, wr);
        chk("subs_path", seq, 32'h0178);
        chk("subs_regwrites", rw, 1);

        do_instr(20'h0A000, -1, seq, pcw, mw, rw, ra, wr);
        chk("beq_path", seq, 32'h019);
        chk("beq_pcwrite", pcw, 1);

        do_instr(20'h1A000, -1, seq, pcw, mw, rw, ra, wr);
        chk("bne_path", seq, 32'h019);
        chk("bne_pcwrite", pcw, 0);

        do_instr(20'hE5921, -1, seq, pcw, mw, rw, ra, wr);
        chk("ldr_path", seq, 32'h01234);
        chk("ldr_adrsrc", ra, 1);
        chk("ldr_resultsrc", wr, 1);
        chk("ldr_regwrites", rw, 1);

        do_instr(20'hE5821, -1, seq, pcw, mw, rw, ra, wr);
        chk("str_path", seq, 32'h0125);
        chk("str_memwrites", mw, 1);
        chk("str_regwrites", rw, 0);

        do_instr(20'h15821, -1, seq, pcw, mw, rw, ra, wr);
        chk("strne_path", seq, 32'h0125);
        chk("strne_memwrites", mw, 0);

        // Abort an LDR in MEMRD with a one-cycle reset pulse
        Instr = 20'hE5921;
        guard = 0;
        while (mstep != 3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reached_memrd", mstep, 3);
        reset = 1'b0;
        #2;
        chk("abort_state", State, 0);
        chk("abort_strobes", {PCWrite, IRWrite, MemWrite, RegWrite}, 0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("abort_refetch_state", State, 0);
        chk("abort_refetch_irwrite", IRWrite, 1);
        chk("abort_refetch_regwrite", RegWrite, 0);

        do_instr(20'hEC000, -1, seq, pcw, mw, rw, ra, wr);
        chk("undef_path", seq, 32'h01);
        chk("undef_writes", mw + rw, 0);

        for (int n = 0; n < 200; n++) begin
            do_instr(20'($urandom), -1, seq, pcw, mw, rw, ra, wr);
        end

        @(negedge clk);
        #3;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
